// File: rtl/serial_work_host_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | serial_work_host_pkg                                            |
// | Shared UART state encodings and work/nonce sizing.              |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package serial_work_host_pkg;

  localparam int WORK_BYTES  = 64;
  localparam int NONCE_BYTES = 4;
  localparam int WORK_BITS   = WORK_BYTES * 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef logic [7:0] byte_t;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_work_host_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | serial_work_host_if                                             |
// | Work submission, serial lines and nonce results of the host.    |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
interface serial_work_host_if;

  logic         work_valid;
  logic         work_ready;
  logic [255:0] midstate;
  logic [255:0] data2;
  logic         TxD;
  logic         RxD;
  logic         nonce_valid;
  logic [31:0]  nonce;
  logic         rx_frame_err;

  modport slave (
    input  work_valid, midstate, data2, RxD,
    output work_ready, TxD, nonce_valid, nonce, rx_frame_err
  );

  modport master (
    output work_valid, midstate, data2, RxD,
    input  work_ready, TxD, nonce_valid, nonce, rx_frame_err
  );

endinterface
`default_nettype wire

// File: rtl/serial_work_host_uart_byte_rx.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | uart_byte_rx                                                    |
// | 8N1 byte receiver with 2-flop synchroniser and start-glitch     |
// | rejection. Outputs are single-cycle strobes at the stop sample. |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module uart_byte_rx
  import serial_work_host_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  rxd_i,
  output logic  byte_valid_o,
  output byte_t byte_data_o,
  output logic  frame_err_o
);

  localparam int            CW          = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic          sync1_q, sync2_q, prev_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  byte_t         data_q, data_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
    end else begin
      sync1_q <= rxd_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    data_d       = data_q;
    byte_valid_o = 1'b0;
    frame_err_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        // Line back high at mid start bit means it was noise, not a frame.
        if (cnt_q == C_HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync2_q ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == C_BIT_LAST) begin
          cnt_d  = '0;
          data_d = {sync2_q, data_q[7:1]};
          if (bit_q == 3'd7) state_d = ST_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (cnt_q == C_BIT_LAST) begin
          cnt_d        = '0;
          state_d      = ST_IDLE;
          byte_valid_o = sync2_q;
          frame_err_o  = !sync2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  assign byte_data_o = data_q;

endmodule
`default_nettype wire

// File: rtl/serial_work_host.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | serial_work_host                                                |
// | Serialises 64-byte work units onto TxD and assembles 4-byte     |
// | golden nonces from RxD. Both directions run independently.      |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module serial_work_host
  import serial_work_host_pkg::*;
#(
  parameter int CLK_HZ          = 50000000,
  parameter int BAUD            = 115200,
  parameter int RX_TIMEOUT_BITS = 40
) (
  input  logic               clk,
  input  logic               reset,
  serial_work_host_if.slave  bus
);

  localparam int            CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int            BW           = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] C_BIT_LAST   = BW'(CLKS_PER_BIT - 1);
  localparam logic [5:0]    C_LAST_BYTE  = 6'(WORK_BYTES - 1);
  localparam int            TIMEOUT_CLKS = RX_TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int            IW           = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [IW-1:0] C_TIMEOUT    = IW'(TIMEOUT_CLKS);

  // ---------------- transmit ----------------
  logic [1:0]           tx_state_q, tx_state_d;
  logic [BW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [5:0]           tx_byte_q, tx_byte_d;
  logic [WORK_BITS-1:0] tx_shift_q, tx_shift_d;
  byte_t                w_tx_byte;
  logic                 w_txd;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_byte_q  <= '0;
      tx_shift_q <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_byte_q  <= tx_byte_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_byte_d  = tx_byte_q;
    tx_shift_d = tx_shift_q;
    case (tx_state_q)
      ST_IDLE: begin
        if (bus.work_valid) begin
          tx_shift_d = {bus.midstate, bus.data2};
          tx_state_d = ST_START;
          tx_cnt_d   = '0;
          tx_byte_d  = '0;
        end
      end
      ST_START: begin
        if (tx_cnt_q == C_BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = ST_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (tx_cnt_q == C_BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) tx_state_d = ST_STOP;
          else                  tx_bit_d   = tx_bit_q + 3'd1;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: begin
        if (tx_cnt_q == C_BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_byte_q == C_LAST_BYTE) begin
            tx_state_d = ST_IDLE;
          end else begin
            tx_byte_d  = tx_byte_q + 6'd1;
            tx_shift_d = tx_shift_q << 8;
            tx_state_d = ST_START;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
    endcase
  end

  // The byte on the wire is always the top byte of the shift register.
  assign w_tx_byte = tx_shift_q[WORK_BITS-1 -: 8];

  always_comb begin
    w_txd = 1'b1;
    case (tx_state_q)
      ST_START: w_txd = 1'b0;
      ST_DATA:  w_txd = w_tx_byte[tx_bit_q];
      default:  w_txd = 1'b1;
    endcase
  end

  assign bus.TxD        = w_txd;
  assign bus.work_ready = (tx_state_q == ST_IDLE);

  // ---------------- receive ----------------
  logic          w_byte_valid, w_frame_err;
  byte_t         w_byte_data;
  logic [1:0]    idx_q, idx_d;
  logic [23:0]   acc_q, acc_d;
  logic [31:0]   nonce_q, nonce_d;
  logic          nonce_valid_q, nonce_valid_d;
  logic          frame_err_q;
  logic [IW-1:0] idle_q, idle_d;

  uart_byte_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk          (clk),
    .reset        (reset),
    .rxd_i        (bus.RxD),
    .byte_valid_o (w_byte_valid),
    .byte_data_o  (w_byte_data),
    .frame_err_o  (w_frame_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q         <= '0;
      acc_q         <= '0;
      nonce_q       <= '0;
      nonce_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      idle_q        <= '0;
    end else begin
      idx_q         <= idx_d;
      acc_q         <= acc_d;
      nonce_q       <= nonce_d;
      nonce_valid_q <= nonce_valid_d;
      frame_err_q   <= w_frame_err;
      idle_q        <= idle_d;
    end
  end

  always_comb begin
    idx_d         = idx_q;
    acc_d         = acc_q;
    nonce_d       = nonce_q;
    nonce_valid_d = 1'b0;
    idle_d        = (idle_q == C_TIMEOUT) ? idle_q : idle_q + 1'b1;
    if (w_byte_valid) begin
      idle_d = '0;
      if (idx_q == 2'd3) begin
        nonce_d       = {w_byte_data, acc_q};
        nonce_valid_d = 1'b1;
        idx_d         = '0;
      end else begin
        case (idx_q)
          2'd0:    acc_d[7:0]   = w_byte_data;
          2'd1:    acc_d[15:8]  = w_byte_data;
          default: acc_d[23:16] = w_byte_data;
        endcase
        idx_d = idx_q + 2'd1;
      end
    end else if (w_frame_err) begin
      idx_d = '0;
    end else if (idle_q == C_TIMEOUT && idx_q != 2'd0) begin
      // Stale partial nonce is dropped silently.
      idx_d = '0;
    end
  end

  assign bus.nonce        = nonce_q;
  assign bus.nonce_valid  = nonce_valid_q;
  assign bus.rx_frame_err = frame_err_q;

endmodule
`default_nettype wire
